fib_requester: RTL and testbench
================================

# fib_requester

Command-side initiator for the Fibonacci compute engine. It accepts indices `n` on a valid/ready command port, drives the engine's level start/done handshake, and captures the engine result. It returns the result on a valid/ready response port with overflow and timeout status. It sits between the host-facing command path and one engine instance, sharing the engine's clock and reset.

## Interface
- `TIMEOUT`, default 70000: cycles allowed in ISSUE before the engine is declared hung (must be ≥ 2).
- `MAX_N_NOOVF`, default 24: largest `n` whose F(n) fits in 16 bits.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command. Combinational, equal to (state == IDLE).
- `cmd_n` in 16: requested index.
- `eng_start` out 1: engine start level.
- `eng_din` out 16: engine index. Held stable for the whole transaction.
- `eng_dout` in 16: engine result. Valid whenever `eng_done` = 1.
- `eng_done` in 1: engine done level.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_value` out 16: captured F(n) mod 2^16.
- `rsp_n` out 16: index that produced the response.
- `rsp_ovf` out 1: `rsp_n` > `MAX_N_NOOVF`, so the value has wrapped.
- `rsp_timeout` out 1: engine did not complete; `rsp_value` = 0.
- `fault` out 1: sticky; set by a timeout and cleared only by reset.
- `busy` out 1: state ≠ IDLE.
- `txn_count` out 16: completed responses; wraps 0xFFFF→0.

## Operation
- States: IDLE, ISSUE, RELEASE, RESPOND, FAULT.
- IDLE:
  - On `cmd_valid && cmd_ready`: latch `cmd_n` into `eng_din` and `rsp_n`.
  - Latch `rsp_ovf` = (`cmd_n` > `MAX_N_NOOVF`).
  - Clear the watchdog and go to ISSUE.
  - `eng_din` is not altered outside IDLE acceptance.
- ISSUE:
  - `eng_start` = 1 and the watchdog counts once per cycle.
  - When `eng_done` is sampled 1: `rsp_value` ← `eng_dout`, `rsp_timeout` ← 0, `eng_start` ← 0, go to RELEASE.
  - Otherwise, when the watchdog reaches `TIMEOUT`-1: `eng_start` ← 0, `rsp_value` ← 0, `rsp_timeout` ← 1, `fault` ← 1, go to RESPOND.
  - If `eng_done` and timeout occur in the same cycle, `eng_done` wins.
- RELEASE:
  - `eng_start` = 0.
  - Wait until `eng_done` is sampled 0, then go to RESPOND. This keeps the engine back in IDLE before any new start.
  - No timeout applies here.
- RESPOND:
  - `rsp_valid` = 1. All `rsp_*` fields are stable while `rsp_valid` is high.
  - On `rsp_ready`: `rsp_valid` ← 0 and `txn_count` increments.
  - Next state is IDLE, or FAULT if `fault` = 1.
- FAULT:
  - `cmd_ready` = 0 and `eng_start` = 0.
  - Remains until reset.
- `eng_done` = 1 while in IDLE is ignored and does not block acceptance.
- All comparisons are unsigned. `rsp_ovf` is computed from `n` only, never from the engine.

## Timing
- Reset values:
  - `eng_start` 0, `eng_din` 0.
  - `rsp_valid` 0, `rsp_value` 0, `rsp_n` 0, `rsp_ovf` 0, `rsp_timeout` 0.
  - `fault` 0, `txn_count` 0, state IDLE; hence `cmd_ready` 1 and `busy` 0.
- Reset asserted mid-transaction returns all outputs to these values immediately, with no response emitted.
- Accept at edge E0 → `eng_start` high after E0.
- `eng_done` sampled high at edge Ed → `eng_start` low after Ed.
- `eng_done` sampled low at edge Er → `rsp_valid` high after Er.
- Handshake at edge Eh → `rsp_valid` low and `cmd_ready` high after Eh. Minimum command spacing is therefore 4 cycles plus engine latency.
- Timeout: `rsp_valid` rises exactly `TIMEOUT` cycles after `eng_start` rises.
- All outputs are registered except `cmd_ready` and `busy`, which decode state.

## Structure
- `fib_pkg`:
  - `fib_req_state_t` enum (3-bit).
  - `FIB_W` = 16.
  - `FIB_MAX_N_NOOVF` = 24.
- Sub-module `fib_watchdog`:
  - Parameter `TIMEOUT`.
  - Inputs `clk`, `reset`, `clear`, `en`; output `expired`.
  - Counter width $clog2(`TIMEOUT`).
  - `expired` is combinational on count == `TIMEOUT`-1 && `en`.

## Test plan
- Basic result: `n`=10 with the real engine → `rsp_value`=55, `rsp_ovf`=0, `rsp_timeout`=0, `txn_count`=1.
- Small indices: back-to-back `n`=0, 1, 2 → values 0, 1, 1. `eng_start` never rises while `eng_done`=1 from the prior transaction.
- Overflow boundary: `n`=24 → 46368 with `rsp_ovf`=0; `n`=25 → 9489 with `rsp_ovf`=1.
- Response backpressure: `n`=7, hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and value 13 stay stable; `cmd_ready` stays 0 until the handshake.
- Hung engine: `TIMEOUT`=16 with a stub whose `eng_done` never rises → `rsp_timeout`=1 and `rsp_value`=0, exactly 16 cycles after `eng_start` rises. Then `fault`=1 and `cmd_ready`=0 until reset; `eng_done` and expiry forced in the same cycle → normal response.
- Mid-operation reset: assert `reset` during ISSUE for `n`=20 → all outputs return to reset values asynchronously. A following `n`=5 → 5.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci requester slice.
// Exports: fib_req_state_t, fib_word_t, FIB_W, FIB_MAX_N_NOOVF.
package fib_pkg;

   localparam int FIB_W           = 16;
   localparam int FIB_MAX_N_NOOVF = 24;

   typedef logic [FIB_W-1:0] fib_word_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      RELEASE,
      RESPOND,
      FAULT
   } fib_req_state_t;

endpackage

// File: rtl/fib_requester_if.sv
// Host-side command/response handshake bundle for fib_requester.
// master: host (drives cmd, consumes rsp); slave: fib_requester.
interface fib_requester_if;
   import fib_pkg::*;

   logic      cmd_valid;
   logic      cmd_ready;
   fib_word_t cmd_n;
   logic      rsp_valid;
   logic      rsp_ready;
   fib_word_t rsp_value;
   fib_word_t rsp_n;
   logic      rsp_ovf;
   logic      rsp_timeout;

   modport master (
      output cmd_valid, cmd_n, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_value,
      input  rsp_n, rsp_ovf, rsp_timeout
   );

   modport slave (
      input  cmd_valid, cmd_n, rsp_ready,
      output cmd_ready, rsp_valid, rsp_value,
      output rsp_n, rsp_ovf, rsp_timeout
   );

endinterface

// File: rtl/fib_watchdog.sv
// Cycle watchdog for the ISSUE phase of a transaction.
// Ports: clk, reset, clear (zero count), en (count), expired (comb).
module fib_watchdog #(
   parameter int TIMEOUT = 70000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   assign expired = en && (count == LAST);

endmodule

// File: rtl/fib_requester.sv
// Command-side initiator for the Fibonacci engine (level start/done).
// Ports: clk, reset, bus (cmd/rsp), eng_*, fault, busy, txn_count.
module fib_requester
   import fib_pkg::*;
#(
   parameter int TIMEOUT     = 70000,
   parameter int MAX_N_NOOVF = FIB_MAX_N_NOOVF
) (
   input  logic            clk,
   input  logic            reset,
   fib_requester_if.slave  bus,
   output logic            eng_start,
   output fib_word_t       eng_din,
   input  fib_word_t       eng_dout,
   input  logic            eng_done,
   output logic            fault,
   output logic            busy,
   output logic [15:0]     txn_count
);

   localparam fib_word_t OVF_LIM = FIB_W'(MAX_N_NOOVF);

   fib_req_state_t state;
   logic           accept;
   logic           expired;

   assign bus.cmd_ready = (state == IDLE);
   assign busy          = (state != IDLE);
   assign accept        = bus.cmd_valid && bus.cmd_ready;

   fib_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wd (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .en     (state == ISSUE),
      .expired(expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         eng_start       <= 1'b0;
         eng_din         <= '0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_value   <= '0;
         bus.rsp_n       <= '0;
         bus.rsp_ovf     <= 1'b0;
         bus.rsp_timeout <= 1'b0;
         fault           <= 1'b0;
         txn_count       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  eng_din     <= bus.cmd_n;
                  bus.rsp_n   <= bus.cmd_n;
                  bus.rsp_ovf <= (bus.cmd_n > OVF_LIM);
                  eng_start   <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               // done beats a same-cycle expiry
               if (eng_done) begin
                  bus.rsp_value   <= eng_dout;
                  bus.rsp_timeout <= 1'b0;
                  eng_start       <= 1'b0;
                  state           <= RELEASE;
               end else if (expired) begin
                  bus.rsp_value   <= '0;
                  bus.rsp_timeout <= 1'b1;
                  bus.rsp_valid   <= 1'b1;
                  eng_start       <= 1'b0;
                  fault           <= 1'b1;
                  state           <= RESPOND;
               end
            end
            RELEASE: begin
               // engine must drop done before a new start can follow
               if (!eng_done) begin
                  bus.rsp_valid <= 1'b1;
                  state         <= RESPOND;
               end
            end
            RESPOND: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  txn_count     <= txn_count + 16'd1;
                  state         <= fault ? FAULT : IDLE;
               end
            end
            FAULT: begin
               eng_start <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fib_requester.sv
// Self-checking bench for fib_requester with a behavioural engine.
// Scoreboard queue of expected responses, checked on each handshake.
module tb_fib_requester;
   import fib_pkg::*;

   localparam int TO = 16;

   typedef struct {
      logic [15:0] n;
      logic [15:0] value;
      logic        ovf;
      logic        tmo;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        eng_start;
   logic        eng_done;
   fib_word_t   eng_din;
   fib_word_t   eng_dout;
   logic        fault;
   logic        busy;
   logic [15:0] txn_count;

   int   n_tests = 0;
   int   n_fail = 0;
   int   exp_txn = 0;
   int   lat = 4;
   bit   hung = 1'b0;
   int   k;
   int   rel;
   int   cyc;
   logic prev_start = 1'b0;
   exp_t sb[$];

   always #5 clk = ~clk;

   fib_requester_if bus ();

   fib_requester #(
      .TIMEOUT    (TO),
      .MAX_N_NOOVF(24)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .eng_start(eng_start),
      .eng_din  (eng_din),
      .eng_dout (eng_dout),
      .eng_done (eng_done),
      .fault    (fault),
      .busy     (busy),
      .txn_count(txn_count)
   );

   function automatic logic [15:0] fib16(input logic [15:0] n);
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] t;
      a = 16'd0;
      b = 16'd1;
      for (int i = 0; i < int'(n); i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // engine: done after lat start cycles, drops 2 cycles after start falls
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         eng_done <= 1'b0;
         eng_dout <= '0;
         k        <= 0;
         rel      <= 0;
      end else if (eng_start) begin
         rel <= 0;
         if (!eng_done && !hung) begin
            k <= k + 1;
            if (k + 1 == lat) begin
               eng_done <= 1'b1;
               eng_dout <= fib16(eng_din);
            end
         end
      end else begin
         k <= 0;
         if (eng_done) begin
            rel <= rel + 1;
            if (rel == 1) eng_done <= 1'b0;
         end
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && eng_start && !prev_start)
         check("start_vs_done", eng_done, 0);
      prev_start = eng_start;
   end

   task automatic check_rst(input string tag);
      check({tag, "_start"}, eng_start, 0);
      check({tag, "_din"}, eng_din, 0);
      check({tag, "_valid"}, bus.rsp_valid, 0);
      check({tag, "_value"}, bus.rsp_value, 0);
      check({tag, "_n"}, bus.rsp_n, 0);
      check({tag, "_ovf"}, bus.rsp_ovf, 0);
      check({tag, "_tmo"}, bus.rsp_timeout, 0);
      check({tag, "_fault"}, fault, 0);
      check({tag, "_txn"}, txn_count, 0);
      check({tag, "_ready"}, bus.cmd_ready, 1);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic send(input logic [15:0] n, input logic [15:0] v,
                       input logic ovf, input logic tmo);
      exp_t e;
      int   w;
      w = 0;
      @(negedge clk);
      while (!bus.cmd_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!bus.cmd_ready) begin
         check("cmd_ready_wait", 0, 1);
         return;
      end
      e.n = n;
      e.value = v;
      e.ovf = ovf;
      e.tmo = tmo;
      sb.push_back(e);
      bus.cmd_valid = 1'b1;
      bus.cmd_n = n;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      check("start_rise", eng_start, 1);
      check("eng_din", eng_din, {16'd0, n});
   endtask

   task automatic get(input int hold, output int cycles);
      exp_t e;
      cycles = 0;
      while (!bus.rsp_valid && cycles < 100) begin
         @(negedge clk);
         if (!bus.rsp_valid) cycles++;
      end
      if (!bus.rsp_valid) begin
         check("rsp_wait", 0, 1);
         return;
      end
      if (sb.size() == 0) begin
         check("sb_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      for (int h = 0; h < hold; h++) begin
         check("hold_valid", bus.rsp_valid, 1);
         check("hold_value", bus.rsp_value, {16'd0, e.value});
         check("hold_cmd_ready", bus.cmd_ready, 0);
         @(negedge clk);
      end
      check("rsp_value", bus.rsp_value, {16'd0, e.value});
      check("rsp_n", bus.rsp_n, {16'd0, e.n});
      check("rsp_ovf", bus.rsp_ovf, e.ovf);
      check("rsp_timeout", bus.rsp_timeout, e.tmo);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      exp_txn++;
      check("rsp_drop", bus.rsp_valid, 0);
      check("txn_count", txn_count, exp_txn);
   endtask

   task automatic run(input logic [15:0] n, input logic [15:0] v,
                      input logic ovf, input int hold);
      send(n, v, ovf, 1'b0);
      get(hold, cyc);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: sim did not end, expected finish");
      $fatal(1);
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_n = '0;
      bus.rsp_ready = 1'b0;
      #12;
      check_rst("reset");
      @(negedge clk);
      reset = 1'b0;

      run(16'd10, 16'd55, 1'b0, 0);
      run(16'd0, 16'd0, 1'b0, 0);
      run(16'd1, 16'd1, 1'b0, 0);
      run(16'd2, 16'd1, 1'b0, 0);
      run(16'd24, 16'd46368, 1'b0, 0);
      run(16'd25, 16'd9489, 1'b1, 0);
      run(16'd7, 16'd13, 1'b0, 5);

      // hung engine: timeout response then sticky fault
      hung = 1'b1;
      send(16'd3, 16'd0, 1'b0, 1'b1);
      get(0, cyc);
      check("timeout_cycles", cyc, TO);
      check("fault_set", fault, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_n = 16'd4;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("fault_ready", bus.cmd_ready, 0);
         check("fault_start", eng_start, 0);
         check("fault_busy", busy, 1);
      end
      bus.cmd_valid = 1'b0;

      // done and expiry collide: done must win
      reset = 1'b1;
      #1;
      check("fault_clr", fault, 0);
      @(negedge clk);
      reset = 1'b0;
      hung = 1'b0;
      lat = TO - 1;
      exp_txn = 0;
      run(16'd3, 16'd2, 1'b0, 0);
      check("collide_fault", fault, 0);
      check("collide_ready", bus.cmd_ready, 1);

      // reset mid-ISSUE drops the transaction
      lat = 8;
      send(16'd20, 16'd6765, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_rst("midrst");
      sb.delete();
      exp_txn = 0;
      @(negedge clk);
      reset = 1'b0;
      lat = 4;
      run(16'd5, 16'd5, 1'b0, 0);

      repeat (2) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
